// File: rtl/fetch_queue_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue_unit: PC owner + {pc, instruction} FIFO feeding decode.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_queue_unit #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [63:0] LAST_ADDR  = 64'd152,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [63:0]                   Inst_Address,
    input  logic [31:0]                   Instruction,
    input  logic                          redirect_valid,
    input  logic [63:0]                   redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [63:0]                   out_pc,
    output logic [31:0]                   out_instruction,
    output logic                          fetch_halted,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    logic [63:0]        pc_q, pc_d;
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               halted_q, halted_d;
    logic [63:0]        entry_pc_q    [FIFO_DEPTH];
    logic [63:0]        entry_pc_d    [FIFO_DEPTH];
    logic [31:0]        entry_instr_q [FIFO_DEPTH];
    logic [31:0]        entry_instr_d [FIFO_DEPTH];

    logic pop;
    logic push;

    assign Inst_Address    = pc_q;
    assign out_valid       = (count_q != '0);
    assign out_pc          = out_valid ? entry_pc_q[rd_ptr_q] : 64'd0;
    assign out_instruction = out_valid ? entry_instr_q[rd_ptr_q] : NOP_INSTR;
    assign fetch_halted    = halted_q;
    assign fifo_count      = count_q;

    assign pop  = out_valid && out_ready;
    assign push = !halted_q && !redirect_valid && ((count_q < c_depth) || pop);

    always_comb begin
        pc_d          = pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        entry_pc_d    = entry_pc_q;
        entry_instr_d = entry_instr_q;

        if (redirect_valid) begin
            // Flush wins over everything; a head popped this cycle is simply gone.
            pc_d     = {redirect_pc[63:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                entry_pc_d[wr_ptr_q]    = pc_q;
                entry_instr_d[wr_ptr_q] = Instruction;
                wr_ptr_d                = wr_ptr_q + 1'b1;
                pc_d                    = pc_q + 64'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{(c_cnt_w-1){1'b0}}, push}
                              - {{(c_cnt_w-1){1'b0}}, pop};
        end

        // PC only moves by push or redirect, so this also holds the flag while halted.
        halted_d = (pc_d > LAST_ADDR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        entry_pc_q    <= entry_pc_d;
        entry_instr_q <= entry_instr_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_queue_unit: directed self-checking bench for fetch_queue_unit.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_queue_unit;

    logic        clk;
    logic        reset;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instruction;
    logic        fetch_halted;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    fetch_queue_unit dut (
        .clk             (clk),
        .reset           (reset),
        .Inst_Address    (Inst_Address),
        .Instruction     (Instruction),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .fetch_halted    (fetch_halted),
        .fifo_count      (fifo_count)
    );

    function automatic logic [31:0] imem(input logic [63:0] a);
        if (a == 64'd0)      return 32'h0000_0513;
        else if (a == 64'd4) return 32'h00F0_0713;
        else                 return 32'hC000_0000 | a[31:0];
    endfunction

    assign Instruction = imem(Inst_Address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_pc"}, out_pc, 64'd0);
        chk({tag, "_instr"}, {32'd0, out_instruction}, 64'h13);
        chk({tag, "_halt"}, {63'd0, fetch_halted}, 64'd0);
        chk({tag, "_addr"}, Inst_Address, 64'd0);
        chk({tag, "_count"}, {61'd0, fifo_count}, 64'd0);
    endtask

    initial begin
        reset          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        step();
        step();
        chk_reset_outputs("rst");

        // Streaming with out_ready held high
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("s1_valid", {63'd0, out_valid}, 64'd1);
        chk("s1_pc", out_pc, 64'd0);
        chk("s1_instr", {32'd0, out_instruction}, 64'h0000_0513);
        chk("s1_addr", Inst_Address, 64'd4);
        step();
        chk("s2_pc", out_pc, 64'd4);
        chk("s2_instr", {32'd0, out_instruction}, 64'h00F0_0713);
        chk("s2_count", {61'd0, fifo_count}, 64'd1);
        step();
        chk("s3_pc", out_pc, 64'd8);
        chk("s3_instr", {32'd0, out_instruction}, 64'hC000_0008);
        chk("s3_count", {61'd0, fifo_count}, 64'd1);

        // Backpressure from reset for 6 cycles
        reset     = 1'b0;
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("bp_count", {61'd0, fifo_count}, 64'd4);
        chk("bp_addr", Inst_Address, 64'd16);
        chk("bp_pc", out_pc, 64'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("bp_drain_pc%0d", i), out_pc, 64'(4 * i));
            chk($sformatf("bp_drain_cnt%0d", i), {61'd0, fifo_count}, 64'd4);
            chk($sformatf("bp_drain_addr%0d", i), Inst_Address, 64'(16 + 4 * i));
        end

        // Full FIFO with out_ready toggling 0,1
        out_ready = 1'b0;
        step();
        chk("ft0_pc", out_pc, 64'd16);
        chk("ft0_count", {61'd0, fifo_count}, 64'd4);
        chk("ft0_addr", Inst_Address, 64'd32);
        out_ready = 1'b1;
        step();
        chk("ft1_pc", out_pc, 64'd20);
        chk("ft1_count", {61'd0, fifo_count}, 64'd4);
        chk("ft1_addr", Inst_Address, 64'd36);
        chk("ft1_instr", {32'd0, out_instruction}, 64'hC000_0014);

        // Redirect with FIFO holding 8..20
        reset     = 1'b0;
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b1;
        step();
        step();
        chk("rd_pre_pc", out_pc, 64'd8);
        chk("rd_pre_count", {61'd0, fifo_count}, 64'd4);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h26;
        step();
        redirect_valid = 1'b0;
        chk("rd_count", {61'd0, fifo_count}, 64'd0);
        chk("rd_addr", Inst_Address, 64'h24);
        chk("rd_valid", {63'd0, out_valid}, 64'd0);
        step();
        chk("rd_tgt_valid", {63'd0, out_valid}, 64'd1);
        chk("rd_tgt_pc", out_pc, 64'h24);
        chk("rd_tgt_instr", {32'd0, out_instruction}, 64'hC000_0024);

        // Halt near LAST_ADDR
        redirect_valid = 1'b1;
        redirect_pc    = 64'd144;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk("h_pre_halt", {63'd0, fetch_halted}, 64'd0);
        chk("h_pre_pc", out_pc, 64'd148);
        step();
        chk("h_halt", {63'd0, fetch_halted}, 64'd1);
        chk("h_addr", Inst_Address, 64'd156);
        chk("h_last_pc", out_pc, 64'd152);
        step();
        chk("h_empty_valid", {63'd0, out_valid}, 64'd0);
        chk("h_empty_instr", {32'd0, out_instruction}, 64'h13);
        chk("h_empty_pc", out_pc, 64'd0);
        chk("h_hold_addr", Inst_Address, 64'd156);
        chk("h_hold_halt", {63'd0, fetch_halted}, 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h88;
        step();
        redirect_valid = 1'b0;
        chk("h_clear", {63'd0, fetch_halted}, 64'd0);
        chk("h_clear_addr", Inst_Address, 64'h88);

        // Reset in the middle of operation
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'd28;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("mr_pre_count", {61'd0, fifo_count}, 64'd3);
        chk("mr_pre_addr", Inst_Address, 64'd40);
        reset = 1'b0;
        step();
        chk_reset_outputs("mr");
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mr_r1_pc", out_pc, 64'd0);
        chk("mr_r1_instr", {32'd0, out_instruction}, 64'h0000_0513);
        step();
        chk("mr_r2_pc", out_pc, 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
